// File: rtl/block_pe_sequencer.sv
// block_pe_sequencer: job controller for one Block_PE tile.
// Clears the PE, gates operand pairs, drains and captures the result.
module block_pe_sequencer #(
  parameter int CNT_W     = 8,
  parameter int DRAIN_CYC = 2,
  parameter int OUT_LAT   = 2
) (
  input  logic                    clk_i,
  input  logic                    rstn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_prec_mode,
  input  logic [1:0]              cmd_FP_mode,
  input  logic [1:0]              cmd_prec_mode_quan,
  input  logic [1:0]              cmd_FP_mode_quan,
  input  logic [CNT_W-1:0]        cmd_num_blocks,
  input  logic                    op_valid,
  output logic                    op_ready,
  output logic [1:0]              prec_mode,
  output logic [1:0]              FP_mode,
  output logic [1:0]              prec_mode_quan,
  output logic [1:0]              FP_mode_quan,
  output logic                    A_valid,
  output logic                    B_valid,
  input  logic                    A_ready,
  input  logic                    B_ready,
  output logic                    send_output,
  output logic                    pe_clear,
  input  logic [0:7][0:7][7:0]    Out,
  input  logic [7:0]              shared_exp_out,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [0:7][0:7][7:0]    res_data,
  output logic [7:0]              res_exp,
  output logic                    busy
);

  localparam int TMAX =
    (DRAIN_CYC > OUT_LAT + 1) ? DRAIN_CYC : OUT_LAT + 1;
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [TW-1:0] DRAIN_END = TW'(DRAIN_CYC - 1);
  localparam logic [TW-1:0] SEND_END  = TW'(OUT_LAT);
  localparam logic [TW-1:0] T_ONE     = TW'(1);
  localparam logic [CNT_W-1:0] C_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_SEND,
    S_RESULT
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] rem_d;
  logic [TW-1:0]    tmr_q;
  logic [TW-1:0]    tmr_d;
  logic             accept;
  logic             capture;
  logic             fire;

  // next-state, counters and handshake gating
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    tmr_d     = tmr_q;
    accept    = 1'b0;
    capture   = 1'b0;
    fire      = 1'b0;
    cmd_ready = 1'b0;
    op_ready  = 1'b0;
    A_valid   = 1'b0;
    B_valid   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = rstn;
        if (cmd_valid) begin
          accept  = 1'b1;
          rem_d   = cmd_num_blocks;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        tmr_d   = '0;
        state_d = (rem_q == '0) ? S_DRAIN : S_FEED;
      end
      S_FEED: begin
        A_valid  = op_valid;
        B_valid  = op_valid;
        op_ready = A_ready & B_ready;
        fire     = op_valid & A_ready & B_ready;
        if (fire) begin
          rem_d = rem_q - C_ONE;
          if (rem_q == C_ONE) begin
            tmr_d   = '0;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        tmr_d = tmr_q + T_ONE;
        if (tmr_q == DRAIN_END) begin
          tmr_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        tmr_d = tmr_q + T_ONE;
        if (tmr_q == SEND_END) begin
          capture = 1'b1;
          state_d = S_RESULT;
        end
      end
      S_RESULT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state, counters and state-decoded registered strobes
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      tmr_q       <= '0;
      pe_clear    <= 1'b0;
      send_output <= 1'b0;
      res_valid   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      tmr_q       <= tmr_d;
      pe_clear    <= (state_d == S_CLEAR);
      send_output <= (state_d == S_SEND);
      res_valid   <= (state_d == S_RESULT);
    end
  end

  // job modes latch on command accept only
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      prec_mode      <= 2'b00;
      FP_mode        <= 2'b00;
      prec_mode_quan <= 2'b00;
      FP_mode_quan   <= 2'b00;
    end else if (accept) begin
      prec_mode      <= cmd_prec_mode;
      FP_mode        <= cmd_FP_mode;
      prec_mode_quan <= cmd_prec_mode_quan;
      FP_mode_quan   <= cmd_FP_mode_quan;
    end
  end

  // result capture at the end of the last send cycle
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      res_data <= '0;
      res_exp  <= '0;
    end else if (capture) begin
      res_data <= Out;
      res_exp  <= shared_exp_out;
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_block_pe_sequencer.sv
// tb_block_pe_sequencer: job-level checks of the PE sequencer
// against per-job expectations derived from the schedule rules.
module tb_block_pe_sequencer;

  localparam int CNT_W     = 8;
  localparam int DRAIN_CYC = 2;
  localparam int OUT_LAT   = 2;

  logic                 clk_i = 1'b0;
  logic                 rstn;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_prec_mode;
  logic [1:0]           cmd_FP_mode;
  logic [1:0]           cmd_prec_mode_quan;
  logic [1:0]           cmd_FP_mode_quan;
  logic [CNT_W-1:0]     cmd_num_blocks;
  logic                 op_valid;
  logic                 op_ready;
  logic [1:0]           prec_mode;
  logic [1:0]           FP_mode;
  logic [1:0]           prec_mode_quan;
  logic [1:0]           FP_mode_quan;
  logic                 A_valid;
  logic                 B_valid;
  logic                 A_ready;
  logic                 B_ready;
  logic                 send_output;
  logic                 pe_clear;
  logic [0:7][0:7][7:0] pe_out;
  logic [7:0]           pe_exp;
  logic                 res_valid;
  logic                 res_ready;
  logic [0:7][0:7][7:0] res_data;
  logic [7:0]           res_exp;
  logic                 busy;

  block_pe_sequencer #(
    .CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC), .OUT_LAT(OUT_LAT)
  ) dut (
    .clk_i(clk_i), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_prec_mode(cmd_prec_mode), .cmd_FP_mode(cmd_FP_mode),
    .cmd_prec_mode_quan(cmd_prec_mode_quan),
    .cmd_FP_mode_quan(cmd_FP_mode_quan),
    .cmd_num_blocks(cmd_num_blocks),
    .op_valid(op_valid), .op_ready(op_ready),
    .prec_mode(prec_mode), .FP_mode(FP_mode),
    .prec_mode_quan(prec_mode_quan), .FP_mode_quan(FP_mode_quan),
    .A_valid(A_valid), .B_valid(B_valid),
    .A_ready(A_ready), .B_ready(B_ready),
    .send_output(send_output), .pe_clear(pe_clear),
    .Out(pe_out), .shared_exp_out(pe_exp),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_exp(res_exp), .busy(busy)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // PE model: result valid OUT_LAT cycles into send_output, noise otherwise
  logic [7:0]   j_pat = 8'h00;
  logic [7:0]   j_exp = 8'h00;
  logic [511:0] noise = '0;
  logic [7:0]   noise8 = 8'h00;
  int           send_cnt = 0;

  always @(posedge clk_i) begin
    send_cnt <= send_output ? send_cnt + 1 : 0;
    noise    <= {$urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom};
    noise8   <= 8'($urandom);
  end

  assign pe_out = (send_output && send_cnt >= OUT_LAT) ? {64{j_pat}} : noise;
  assign pe_exp = (send_output && send_cnt >= OUT_LAT) ? j_exp : noise8;

  // per-job observations
  bit         mon_en = 1'b0;
  int         j_k = 0;
  logic [7:0] j_md = 8'h00;
  bit         acc_seen, rv_seen, done;
  int         acc_edge, clr_edge, fire_edge, rv_edge, ret_edge;
  int         n_clr, n_fire, n_send;
  int         feed_bad, mode_bad, res_bad, hs_bad;
  bit         in_feed;

  always @(negedge clk_i) begin
    if (mon_en) begin
      if (cmd_valid && cmd_ready) begin
        acc_seen = 1'b1;
        acc_edge = cyc + 1;
      end
      if (cmd_ready === busy) hs_bad++;
      if (res_valid && cmd_ready) hs_bad++;
      in_feed = (n_clr > 0) && (cyc > clr_edge) && (n_fire < j_k);
      if (pe_clear) begin
        n_clr++;
        clr_edge = cyc;
      end
      if (in_feed) begin
        if (A_valid !== op_valid || B_valid !== op_valid ||
            op_ready !== (A_ready & B_ready)) feed_bad++;
        if (op_valid && A_ready && B_ready) begin
          n_fire++;
          fire_edge = cyc + 1;
        end
      end else if (A_valid || B_valid || op_ready) begin
        feed_bad++;
      end
      if (acc_seen && cyc >= acc_edge && !done &&
          {prec_mode, FP_mode, prec_mode_quan, FP_mode_quan} !== j_md)
        mode_bad++;
      if (send_output) n_send++;
      if (res_valid && !done) begin
        if (!rv_seen) begin
          rv_seen = 1'b1;
          rv_edge = cyc;
        end
        if (res_data !== {64{j_pat}} || res_exp !== j_exp) res_bad++;
        if (res_ready) begin
          done     = 1'b1;
          ret_edge = cyc + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic mon_clear();
    acc_seen = 0; rv_seen = 0; done = 0;
    n_clr = 0; n_fire = 0; n_send = 0;
    feed_bad = 0; mode_bad = 0; res_bad = 0; hs_bad = 0;
    acc_edge = 0; clr_edge = 0; fire_edge = 0; rv_edge = 0;
  endtask

  task automatic set_cmd(input int k, input logic [7:0] md);
    {cmd_prec_mode, cmd_FP_mode, cmd_prec_mode_quan, cmd_FP_mode_quan} = md;
    cmd_num_blocks = 8'(k);
    cmd_valid = 1'b1;
  endtask

  // sty: 0 continuous, 1 directed toggles, 2 random stalls
  task automatic run_job(input int k, input logic [7:0] md,
                         input logic [7:0] pat, input logic [7:0] ex,
                         input int sty, input int rr_hold,
                         input bit chain, input int nk,
                         input logic [7:0] nmd, input bit chk_chain);
    bit ov_pat[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int prev_ret;
    int rvc;
    bit tmo;
    prev_ret = ret_edge;
    mon_clear();
    j_k = k; j_md = md; j_pat = pat; j_exp = ex;
    set_cmd(k, md);
    rvc = 0;
    tmo = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk_i); #1;
      if (done) begin
        tmo = 1'b0;
        break;
      end
      if (acc_seen) cmd_valid = 1'b0;
      case (sty)
        0: begin
          op_valid = 1'b1; A_ready = 1'b1; B_ready = 1'b1;
        end
        1: begin
          op_valid = ov_pat[i % 6]; A_ready = 1'b1;
          B_ready = (i % 3 != 2);
        end
        default: begin
          op_valid = ($urandom % 4) != 0;
          A_ready  = ($urandom % 3) != 0;
          B_ready  = ($urandom % 3) != 0;
        end
      endcase
      if (res_valid) rvc++;
      res_ready = (rr_hold == 0) || (rvc > rr_hold);
      if (chain && res_valid) set_cmd(nk, nmd);
    end
    chk("job_timeout", tmo, 0);
    chk("clear_count", n_clr, 1);
    chk("clear_edge", clr_edge, acc_edge);
    chk("fires", n_fire, k);
    chk("send_cycles", n_send, OUT_LAT + 1);
    if (k == 0)
      chk("lat_k0", rv_edge - acc_edge, 1 + DRAIN_CYC + OUT_LAT + 1);
    else
      chk("lat_drain", rv_edge - fire_edge, DRAIN_CYC + OUT_LAT + 1);
    if (sty == 0)
      chk("lat_accept", rv_edge - acc_edge, 1 + k + DRAIN_CYC + OUT_LAT + 1);
    chk("feed_gating", feed_bad, 0);
    chk("mode_stable", mode_bad, 0);
    chk("result_data", res_bad, 0);
    chk("cmd_handshake", hs_bad, 0);
    if (chk_chain) chk("chain_accept", acc_edge, prev_ret + 1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ctrl"}, {prec_mode, FP_mode, prec_mode_quan, FP_mode_quan,
         send_output, pe_clear, res_valid, busy,
         A_valid, B_valid, op_ready, cmd_ready}, 0);
    chk({tag, "_data"}, |res_data, 0);
    chk({tag, "_exp"}, res_exp, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    cmd_valid = 1'b0;
    set_cmd(0, 8'h00);
    cmd_valid = 1'b0;
    op_valid = 1'b0; A_ready = 1'b0; B_ready = 1'b0; res_ready = 1'b0;
    ret_edge = 0;
    mon_clear();
    repeat (3) @(posedge clk_i);
    #1;
    chk_reset_outs("por");
    rstn = 1'b1;
    #1;
    chk("por_cmd_ready", cmd_ready, 1);
    chk("por_busy", busy, 0);
    mon_en = 1'b1;

    run_job(1, 8'h00, 8'b00101100, 8'd121, 0, 0, 0, 0, 8'h00, 0);
    run_job(4, 8'h66, 8'($urandom), 8'($urandom), 1, 0, 0, 0, 8'h00, 0);
    run_job(0, 8'h1b, 8'($urandom), 8'($urandom), 0, 0, 0, 0, 8'h00, 0);
    run_job(2, 8'h99, 8'($urandom), 8'($urandom), 2, 5, 1, 3, 8'h27, 0);
    run_job(3, 8'h27, 8'($urandom), 8'($urandom), 2, 0, 0, 0, 8'h00, 1);

    // abort a K=3 job after two fires
    mon_clear();
    j_k = 3; j_md = 8'h5a; j_pat = 8'($urandom); j_exp = 8'($urandom);
    set_cmd(3, 8'h5a);
    op_valid = 1'b1; A_ready = 1'b1; B_ready = 1'b1; res_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_i); #1;
      if (acc_seen) cmd_valid = 1'b0;
      if (n_fire >= 2) break;
    end
    chk("abort_fires", n_fire, 2);
    chk("abort_busy", busy, 1);
    rstn = 1'b0;
    mon_en = 1'b0;
    #1;
    chk_reset_outs("rst_now");
    repeat (2) @(posedge clk_i);
    #1;
    chk_reset_outs("rst_hold");
    rstn = 1'b1;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    op_valid = 1'b0;
    mon_en = 1'b1;
    run_job(1, 8'h44, 8'($urandom), 8'($urandom), 0, 0, 0, 0, 8'h00, 0);

    run_job(255, 8'hcc, 8'($urandom), 8'($urandom), 0, 0, 0, 0, 8'h00, 0);

    for (int r = 0; r < 6; r++)
      run_job($urandom_range(0, 12), 8'($urandom), 8'($urandom),
              8'($urandom), 2, $urandom_range(0, 3), 0, 0, 8'h00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
